// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the CORDIC engine
// Purpose: operating modes, FSM states, the gain-compensation ratio and the
//          atan(2^-i) table in Q4.20 (floored), shared by the engine and its ROM.
// Ports:   none (package).
package cordic_pkg;

   typedef enum logic {
      ROTATE = 1'b0,
      VECTOR = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // K = 0.607252935 in Q4.20; feed as x_in to get cos/sin without a post-multiply.
   localparam logic [23:0] CORDIC_RATIO = 24'h09B74E;

   localparam int ATAN_TABLE_LEN = 24;

   // atan(2^-i) * 2^20, floored.
   localparam logic [23:0] ATAN_Q20 [0:ATAN_TABLE_LEN-1] = '{
      24'h0C90FD, 24'h076B19, 24'h03EB6E, 24'h01FD5B,
      24'h00FFAA, 24'h007FF5, 24'h003FFE, 24'h001FFF,
      24'h000FFF, 24'h0007FF, 24'h0003FF, 24'h0001FF,
      24'h0000FF, 24'h00007F, 24'h00003F, 24'h00001F,
      24'h00000F, 24'h000007, 24'h000003, 24'h000001,
      24'h000000, 24'h000000, 24'h000000, 24'h000000
   };

endpackage

// File: rtl/cordic_atan_rom.sv
// rtl/cordic_atan_rom.sv - combinational atan(2^-i) lookup rescaled to FRAC_BITS
// Purpose: returns atan(2^-i_idx) in the engine's fixed-point format.
// Ports:   i_idx  [4:0]           iteration index (0..23; larger indices return 0)
//          o_atan [ARG_WIDTH-1:0] angle in radians, FRAC_BITS fractional bits
module cordic_atan_rom
   import cordic_pkg::*;
#(
   parameter int ARG_WIDTH = 24,
   parameter int FRAC_BITS = 20
)(
   input  logic [4:0]           i_idx,
   output logic [ARG_WIDTH-1:0] o_atan
);

   // Headroom so the rescale shift never drops table bits before truncation.
   localparam int WIDE = ARG_WIDTH + 24;

   logic [WIDE-1:0] w_raw;

   always_comb begin
      w_raw = '0;
      if (i_idx < 5'd24) begin
         w_raw = WIDE'(ATAN_Q20[i_idx]);
      end
   end

   // Table is Q.20; move the binary point to FRAC_BITS.
   generate
      if (FRAC_BITS >= 20) begin : g_scale_up
         assign o_atan = ARG_WIDTH'(w_raw << (FRAC_BITS - 20));
      end else begin : g_scale_down
         assign o_atan = ARG_WIDTH'(w_raw >> (20 - FRAC_BITS));
      end
   endgenerate

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative rotation/vectoring CORDIC with valid/ready handshakes
// Purpose: one micro-rotation per clock, ITER_CNT iterations per operation,
//          result held in DONE until the consumer accepts it. Gain is not compensated.
// Ports:   clk, rst_n (sync, active low)
//          in_valid/in_ready, in_mode, x_in, y_in, z_in  operand side
//          out_valid/out_ready, x_out, y_out, z_out      result side
module cordic_engine
   import cordic_pkg::*;
#(
   parameter int ARG_WIDTH = 24,
   parameter int FRAC_BITS = 20,
   parameter int ITER_CNT  = 18
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  mode_e                in_mode,
   input  logic [ARG_WIDTH-1:0] x_in,
   input  logic [ARG_WIDTH-1:0] y_in,
   input  logic [ARG_WIDTH-1:0] z_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ARG_WIDTH-1:0] x_out,
   output logic [ARG_WIDTH-1:0] y_out,
   output logic [ARG_WIDTH-1:0] z_out
);

   localparam int ITER_WIDTH = (ITER_CNT > 1) ? $clog2(ITER_CNT) : 1;
   localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(ITER_CNT - 1);

   state_e                      r_state;
   mode_e                       r_mode;
   logic [ITER_WIDTH-1:0]       r_count;
   logic signed [ARG_WIDTH-1:0] r_x, r_y, r_z;
   logic [ARG_WIDTH-1:0]        r_x_out, r_y_out, r_z_out;
   logic                        r_out_valid;

   logic signed [ARG_WIDTH-1:0] w_sx, w_sy, w_atan;
   logic signed [ARG_WIDTH-1:0] w_x_nx, w_y_nx, w_z_nx;
   logic                        w_dir;

   cordic_atan_rom #(
      .ARG_WIDTH (ARG_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_atan_rom (
      .i_idx  (5'(r_count)),
      .o_atan (w_atan)
   );

   assign w_sx = r_x >>> r_count;
   assign w_sy = r_y >>> r_count;

   // Rotation drives z toward 0; vectoring drives y toward 0.
   assign w_dir  = (r_mode == ROTATE) ? ~r_z[ARG_WIDTH-1] : r_y[ARG_WIDTH-1];
   assign w_x_nx = w_dir ? (r_x - w_sy)   : (r_x + w_sy);
   assign w_y_nx = w_dir ? (r_y + w_sx)   : (r_y - w_sx);
   assign w_z_nx = w_dir ? (r_z - w_atan) : (r_z + w_atan);

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign x_out     = r_x_out;
   assign y_out     = r_y_out;
   assign z_out     = r_z_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_mode      <= ROTATE;
         r_count     <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_z         <= '0;
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_z_out     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x     <= x_in;
                  r_y     <= y_in;
                  r_z     <= (in_mode == VECTOR) ? '0 : z_in;
                  r_mode  <= in_mode;
                  r_count <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_x <= w_x_nx;
               r_y <= w_y_nx;
               r_z <= w_z_nx;
               if (r_count == LAST_ITER) begin
                  // Capture the final iteration straight into the output registers.
                  r_x_out     <= w_x_nx;
                  r_y_out     <= w_y_nx;
                  r_z_out     <= w_z_nx;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_count <= r_count + ITER_WIDTH'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
